// File: rtl/imem_boot_loader.sv
// imem_boot_loader: framed byte-stream loader for the 32-byte instruction memory.
// Frame: SYNC_BYTE, LEN, LEN data bytes, CHK (8-bit sum of data bytes).
// Data bytes are written to consecutive byte addresses starting at 0.
// The core stays held until a frame passes its length and checksum checks.
module imem_boot_loader #(
    parameter int unsigned MEM_BYTES = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         start,
    output logic                         mem_we,
    output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
    output logic [7:0]                   mem_wdata,
    output logic                         cpu_hold,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q;
    logic [LW-1:0]   len_q;
    logic [AW-1:0]   cnt_q;
    logic [7:0]      sum_q;
    logic            in_ready_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [7:0]      mem_wdata_q;
    logic            cpu_hold_q;
    logic            done_q;
    logic            err_q;

    logic            accept;
    logic            len_bad;
    logic            last_byte;
    logic [7:0]      sum_d;

    // Handshake, length-bounds and last-byte decode for the current input.
    always_comb begin
        accept    = in_valid && in_ready_q;
        len_bad   = (in_data == 8'd0) || ({24'd0, in_data} > 32'(MEM_BYTES));
        last_byte = ({1'b0, cnt_q} == (len_q - 1'b1));
        sum_d     = sum_q + in_data;
    end

    // Frame parser FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        state_q <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (len_bad) begin
                            state_q    <= S_ERR;
                            err_q      <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            len_q   <= in_data[LW-1:0];
                            cnt_q   <= '0;
                            sum_q   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt_q;
                        mem_wdata_q <= in_data;
                        sum_q       <= sum_d;
                        cnt_q       <= cnt_q + 1'b1;
                        if (last_byte) begin
                            state_q <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (in_data == sum_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed-vector bench for imem_boot_loader: one record per clock cycle,
// outputs sampled 1 time unit after the rising edge.
module tb_imem_boot_loader;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       start;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    imem_boot_loader #(.MEM_BYTES(32), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       s;
        logic       we;
        logic [4:0] addr;
        logic [7:0] wd;
        logic       rdy;
        logic       hold;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic s,
                                input logic we, input logic [4:0] addr, input logic [7:0] wd,
                                input logic rdy, input logic hold, input logic dn, input logic er);
        vec_t t;
        t.v = v; t.d = d; t.s = s; t.we = we; t.addr = addr; t.wd = wd;
        t.rdy = rdy; t.hold = hold; t.dn = dn; t.er = er;
        vq.push_back(t);
    endfunction

    // byte accepted while loader is busy, no write expected
    function automatic void busy(input logic [7:0] d);
        add(1'b1, d, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction

    // data byte whose write appears in the following cycle
    function automatic void wr(input logic [7:0] d, input logic [4:0] a);
        add(1'b1, d, 1'b0, 1'b1, a, d, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic void chk_done(input logic [7:0] d);
        add(1'b1, d, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic void chk_err(input logic [7:0] d);
        add(1'b1, d, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    endfunction

    function automatic void rearm();
        add(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic check_vec(input string name, input vec_t t);
        logic [4:0] act5, exp5;
        logic       bad;
        act5 = {mem_we, in_ready, cpu_hold, done, err};
        exp5 = {t.we, t.rdy, t.hold, t.dn, t.er};
        bad  = (act5 !== exp5);
        if (t.we && ((mem_addr !== t.addr) || (mem_wdata !== t.wd))) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s: got we/rdy/hold/done/err=%b addr=%h wdata=%h, want %b addr=%h wdata=%h",
                     name, act5, mem_addr, mem_wdata, exp5, t.addr, t.wd);
        end
    endtask

    task automatic step(input string name, input vec_t t);
        in_valid = t.v;
        in_data  = t.d;
        start    = t.s;
        @(posedge clk);
        #1;
        check_vec(name, t);
    endtask

    task automatic check_reset_vals(input string name);
        vec_t t;
        t.v = 1'b0; t.d = 8'd0; t.s = 1'b0; t.we = 1'b0; t.addr = 5'd0; t.wd = 8'd0;
        t.rdy = 1'b1; t.hold = 1'b1; t.dn = 1'b0; t.er = 1'b0;
        check_vec(name, t);
        checks++;
        if (mem_addr !== 5'd0 || mem_wdata !== 8'd0) begin
            failures++;
            $display("FAIL %s_addr_data: got addr=%h wdata=%h, want 00 00", name, mem_addr, mem_wdata);
        end
    endtask

    int good_end;
    vec_t rv;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;

        // good frame: sum 8C+01+00+04 = 91
        busy(8'hA5); busy(8'h04);
        wr(8'h8C, 5'd0); wr(8'h01, 5'd1); wr(8'h00, 5'd2); wr(8'h04, 5'd3);
        chk_done(8'h91);
        add(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        good_end = vq.size();
        // bytes offered in DONE are not taken and change nothing
        add(1'b1, 8'hA5, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rearm();

        // bad checksum 31 vs 30, then recovery with a 1-byte frame
        busy(8'hA5); busy(8'h02); wr(8'h10, 5'd0); wr(8'h20, 5'd1);
        chk_err(8'h31);
        add(1'b1, 8'hA5, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        rearm();
        busy(8'hA5); busy(8'h01); wr(8'hFF, 5'd0); chk_done(8'hFF);
        rearm();

        // length bounds: 0 and 33 rejected at the LEN byte
        busy(8'hA5); chk_err(8'h00);
        rearm();
        busy(8'hA5); chk_err(8'h21);
        rearm();
        // LEN = 32, all bytes 01, CHK = 20
        busy(8'hA5); busy(8'h20);
        for (int i = 0; i < 32; i++) wr(8'h01, 5'(i));
        chk_done(8'h20);
        rearm();

        // preamble junk and a 3-cycle gap inside the frame
        busy(8'h00); busy(8'h33); busy(8'hA5); busy(8'h01);
        for (int i = 0; i < 3; i++) add(1'b0, 8'h7E, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        wr(8'h7E, 5'd0); chk_done(8'h7E);
        rearm();

        // sum wrap F0+20 = 110 -> 10; start mid-DATA is ignored
        busy(8'hA5); busy(8'h02);
        add(1'b1, 8'hF0, 1'b1, 1'b1, 5'd0, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
        wr(8'h20, 5'd1); chk_done(8'h10);
        rearm();

        // sync value inside the frame is plain data: A5+A5 = 14A -> 4A
        busy(8'hA5); busy(8'h02); wr(8'hA5, 5'd0); wr(8'hA5, 5'd1); chk_done(8'h4A);
        rearm();

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset_state");
        reset = 1'b0;

        foreach (vq[i]) step($sformatf("vec%0d", i), vq[i]);

        // asynchronous reset between edges while a write pulse is active
        step("ar_sync", vq[0]);
        step("ar_len", vq[1]);
        rv = vq[2];
        step("ar_data", rv);
        #2 reset = 1'b1;
        #1 check_reset_vals("async_reset_now");
        in_valid = 1'b0;
        @(posedge clk);
        #1 check_reset_vals("async_reset_held");
        reset = 1'b0;
        for (int i = 0; i < good_end; i++) step($sformatf("post_reset%0d", i), vq[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
